// File: rtl/res_arb_pkg.sv
// Shared types and widths for the result-RAM arbiter.
//   RES_ADDR_W / RES_DATA_W : geometry of the 16384 x 8 result RAM
//   arb_state_t             : arbiter FSM (free arbitration, or owned by port 0 / port 1)
package res_arb_pkg;
    localparam int RES_ADDR_W = 14;
    localparam int RES_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;
endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker.
//   i_valid    [1:0] requests
//   i_last_gnt       port granted most recently (loses a tie)
//   i_mask     [1:0] ports eligible this cycle
//   o_gnt      [1:0] one-hot grant, zero when nothing eligible
module arb_rr2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_gnt,
    input  logic [1:0] i_mask,
    output logic [1:0] o_gnt
);
    logic [1:0] w_req;

    assign w_req = i_valid & i_mask;

    always_comb begin
        o_gnt = w_req;
        if (w_req == 2'b11)
            o_gnt = i_last_gnt ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/res_mem_arbiter.sv
// Shares the single-port result RAM between the distance-transform engine
// (port 0) and the host readout dumper (port 1).
//   clk, reset            clock, async active-high reset
//   req_valid/wr/lock[2]  per-port request, write flag, hold-ownership flag
//   req_addr0/1, req_wdata0/1  per-port address / write data
//   req_ready[2]          combinational accept
//   rd_valid[2], rd_data  read return, shared data bus (= res_di)
//   res_rd/wr/addr/do     registered RAM command, res_di RAM read data
module res_mem_arbiter
    import res_arb_pkg::*;
#(
    parameter int ADDR_W   = RES_ADDR_W,
    parameter int DATA_W   = RES_DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_wr,
    input  logic [1:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              res_rd,
    output logic              res_wr,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_do,
    input  logic [DATA_W-1:0] res_di
);
    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    arb_state_t        r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic              r_last_gnt, w_last_nx;
    logic              r_res_rd, r_res_wr, r_port;
    logic [ADDR_W-1:0] r_res_addr;
    logic [DATA_W-1:0] r_res_do;
    logic [1:0]        r_rd_valid;

    logic [1:0]        w_mask, w_gnt;
    logic              w_acc, w_port, w_wr, w_lock, w_force;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    always_comb begin
        case (r_state)
            OWN0:    w_mask = 2'b01;
            OWN1:    w_mask = 2'b10;
            default: w_mask = 2'b11;
        endcase
    end

    arb_rr2 u_rr (
        .i_valid    (req_valid),
        .i_last_gnt (r_last_gnt),
        .i_mask     (w_mask),
        .o_gnt      (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_acc     = |w_gnt;
    assign w_port    = w_gnt[1];
    assign w_wr      = req_wr[w_port];
    assign w_lock    = req_lock[w_port];
    assign w_addr    = w_port ? req_addr1  : req_addr0;
    assign w_wdata   = w_port ? req_wdata1 : req_wdata0;

    // Last owned cycle: release regardless of the owner's lock request.
    assign w_force = (r_state != ARB) && (r_cnt == CNT_W'(LOCK_MAX - 1));

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_last_nx  = w_acc ? w_port : r_last_gnt;
        if (r_state == ARB) begin
            if (w_acc && w_lock) begin
                w_state_nx = w_port ? OWN1 : OWN0;
                w_cnt_nx   = '0;
            end
        end else if (w_force) begin
            w_state_nx = ARB;
            w_cnt_nx   = '0;
            w_last_nx  = (r_state == OWN1);
        end else if (w_acc && !w_lock) begin
            w_state_nx = ARB;
            w_cnt_nx   = '0;
        end else begin
            w_cnt_nx   = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB;
            r_cnt      <= '0;
            r_last_gnt <= 1'b1;
            r_res_rd   <= 1'b0;
            r_res_wr   <= 1'b0;
            r_port     <= 1'b0;
            r_res_addr <= '0;
            r_res_do   <= '0;
            r_rd_valid <= 2'b00;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_last_gnt <= w_last_nx;
            r_res_rd   <= w_acc && !w_wr;
            r_res_wr   <= w_acc && w_wr;
            if (w_acc) begin
                r_port     <= w_port;
                r_res_addr <= w_addr;
                if (w_wr)
                    r_res_do <= w_wdata;
            end
            // RAM returns data the cycle after res_rd; tag it with the issuing port.
            r_rd_valid <= r_res_rd ? (r_port ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign res_rd   = r_res_rd;
    assign res_wr   = r_res_wr;
    assign res_addr = r_res_addr;
    assign res_do   = r_res_do;
    assign rd_valid = r_rd_valid;
    assign rd_data  = res_di;
endmodule
